// File: rtl/key_move_sequencer.sv
// Frame-synchronous WASD key sequencer: samples HID slots on each vs rising edge and
// issues collision-gated single steps. Define KEY_AUTOREPEAT_EN to enable held-key repeat.
module key_move_sequencer #(
    parameter logic [7:0]  UP_CODE      = 8'h1A,
    parameter logic [7:0]  DOWN_CODE    = 8'h16,
    parameter logic [7:0]  LEFT_CODE    = 8'h04,
    parameter logic [7:0]  RIGHT_CODE   = 8'h07,
    parameter int unsigned REPEAT_DELAY = 12,
    parameter int unsigned REPEAT_RATE  = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       vs,
    input  logic [7:0] keycode [0:5],
    input  logic [3:0] blocked,
    output logic       frame_tick,
    output logic [3:0] dir,
    output logic       move_valid,
    output logic       key_held
);

    typedef enum logic [2:0] {
        StIdle,
        StFirst,
        StWait,
        StRepeat,
        StHold
    } state_t;

    state_t     r_state;
    state_t     w_state_d;
    logic       r_vs;
    logic [3:0] r_prev_pressed;
    logic [3:0] r_dir;
    logic [7:0] r_cnt;
    logic       r_frame_tick;
    logic       r_move_valid;
    logic       r_key_held;

    logic       w_tick;
    logic [3:0] w_pressed;
    logic [3:0] w_new_press;
    logic [3:0] w_winner;
    logic [3:0] w_dir_d;
    logic [7:0] w_cnt_d;
    logic [7:0] w_cnt_inc;
    logic       w_step;

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [7:0] DelayCnt = 8'(REPEAT_DELAY);
    localparam logic [7:0] RateCnt  = 8'(REPEAT_RATE);
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{REPEAT_DELAY[7:0], REPEAT_RATE[7:0]};
`endif

    // Priority order up > down > left > right on bits [3:0].
    function automatic logic [3:0] f_top(input logic [3:0] v);
        if (v[3])      return 4'b1000;
        else if (v[2]) return 4'b0100;
        else if (v[1]) return 4'b0010;
        else if (v[0]) return 4'b0001;
        else           return 4'b0000;
    endfunction

    assign w_tick      = ~r_vs & vs;
    assign w_new_press = w_pressed & ~r_prev_pressed;
    assign w_cnt_inc   = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

    always_comb begin
        w_pressed = '0;
        for (int i = 0; i < 6; i++) begin
            if (keycode[i] == UP_CODE)    w_pressed[3] = 1'b1;
            if (keycode[i] == DOWN_CODE)  w_pressed[2] = 1'b1;
            if (keycode[i] == LEFT_CODE)  w_pressed[1] = 1'b1;
            if (keycode[i] == RIGHT_CODE) w_pressed[0] = 1'b1;
        end
    end

    always_comb begin
        if (w_new_press != 4'b0000) begin
            w_winner = f_top(w_new_press);
        end else if ((r_dir & w_pressed) != 4'b0000) begin
            w_winner = r_dir;
        end else begin
            w_winner = f_top(w_pressed);
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_dir_d   = r_dir;
        w_step    = 1'b0;
        if (w_tick) begin
            if (w_winner == 4'b0000) begin
                w_state_d = StIdle;
                w_cnt_d   = 8'd0;
                w_dir_d   = 4'b0000;
            end else if (w_winner != r_dir) begin
                w_state_d = StFirst;
                w_cnt_d   = 8'd1;
                w_dir_d   = w_winner;
                w_step    = 1'b1;
            end else begin
                case (r_state)
`ifdef KEY_AUTOREPEAT_EN
                    // FIRST counts like WAIT so the first repeat lands REPEAT_DELAY frames
                    // after the initial step.
                    StFirst, StWait: begin
                        if (r_cnt == DelayCnt) begin
                            w_state_d = StRepeat;
                            w_cnt_d   = 8'd1;
                            w_step    = 1'b1;
                        end else begin
                            w_state_d = StWait;
                            w_cnt_d   = w_cnt_inc;
                        end
                    end
                    StRepeat: begin
                        if (r_cnt == RateCnt) begin
                            w_cnt_d = 8'd1;
                            w_step  = 1'b1;
                        end else begin
                            w_cnt_d = w_cnt_inc;
                        end
                    end
`else
                    StFirst, StHold: begin
                        w_state_d = StHold;
                    end
`endif
                    default: begin
                        w_state_d = r_state;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state        <= StIdle;
            r_vs           <= 1'b1;
            r_prev_pressed <= 4'b0000;
            r_dir          <= 4'b0000;
            r_cnt          <= 8'd0;
            r_frame_tick   <= 1'b0;
            r_move_valid   <= 1'b0;
            r_key_held     <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_vs         <= vs;
            r_dir        <= w_dir_d;
            r_cnt        <= w_cnt_d;
            r_frame_tick <= w_tick;
            // A blocked step still advances the FSM, only the pulse is dropped.
            r_move_valid <= w_step & ((w_dir_d & blocked) == 4'b0000);
            if (w_tick) begin
                r_prev_pressed <= w_pressed;
                r_key_held     <= |w_pressed;
            end
        end
    end

    assign frame_tick = r_frame_tick;
    assign dir        = r_dir;
    assign move_valid = r_move_valid;
    assign key_held   = r_key_held;

endmodule

// File: tb/tb_key_move_sequencer.sv
// Randomized bench for key_move_sequencer against a frame-level model of key selection
// and step timing; follows KEY_AUTOREPEAT_EN like the design.
module tb_key_move_sequencer;

    localparam int RepDelay = 12;
    localparam int RepRate  = 4;
`ifdef KEY_AUTOREPEAT_EN
    localparam bit AutoRep = 1'b1;
`else
    localparam bit AutoRep = 1'b0;
`endif

    logic       Clk   = 1'b0;
    logic       Reset = 1'b1;
    logic       vs    = 1'b1;
    logic [7:0] keycode [0:5];
    logic [3:0] blocked = 4'b0000;
    logic       frame_tick;
    logic [3:0] dir;
    logic       move_valid;
    logic       key_held;

    int n_checks = 0;
    int n_errors = 0;

    // Frame-level model state
    logic [3:0] m_prev;
    logic [3:0] m_dir;
    int         m_n;
    logic       m_mv;
    logic       m_held;

    logic [3:0] seen_dir;
    logic       seen_mv;

    key_move_sequencer dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .vs         (vs),
        .keycode    (keycode),
        .blocked    (blocked),
        .frame_tick (frame_tick),
        .dir        (dir),
        .move_valid (move_valid),
        .key_held   (key_held)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] top_bit(input logic [3:0] v);
        for (int b = 3; b >= 0; b--) begin
            if (v[b]) return 4'(1 << b);
        end
        return 4'b0000;
    endfunction

    function automatic logic [7:0] code_of(input int b);
        case (b)
            3:       return 8'h1A;
            2:       return 8'h16;
            1:       return 8'h04;
            default: return 8'h07;
        endcase
    endfunction

    // Steps happen at frame 0 of a hold and, with repeat, at DELAY, DELAY+RATE, ...
    function automatic bit step_due(input int n);
        if (!AutoRep) return 1'b0;
        return (n == RepDelay) || ((n > RepDelay) && (((n - RepDelay) % RepRate) == 0));
    endfunction

    task automatic model_reset();
        m_prev = 4'b0000;
        m_dir  = 4'b0000;
        m_n    = 0;
        m_mv   = 1'b0;
        m_held = 1'b0;
    endtask

    task automatic model_tick(input logic [3:0] pressed, input logic [3:0] blk);
        logic [3:0] newp;
        logic [3:0] win;
        bit         step;
        newp = pressed & ~m_prev;
        if (newp != 4'b0000)              win = top_bit(newp);
        else if ((m_dir & pressed) != 0) win = m_dir;
        else                              win = top_bit(pressed);
        step = 1'b0;
        if (win == 4'b0000) begin
            m_dir = 4'b0000;
        end else if (win != m_dir) begin
            m_dir = win;
            m_n   = 0;
            step  = 1'b1;
        end else begin
            m_n++;
            step = step_due(m_n);
        end
        m_mv   = step && ((m_dir & blk) == 4'b0000);
        m_prev = pressed;
        m_held = |pressed;
    endtask

    task automatic scramble();
        for (int i = 0; i < 6; i++) keycode[i] = 8'($urandom);
    endtask

    task automatic load_keys(input logic [3:0] set);
        int start;
        int k;
        for (int i = 0; i < 6; i++) begin
            keycode[i] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            if (keycode[i] inside {8'h1A, 8'h16, 8'h04, 8'h07}) keycode[i] = 8'h00;
        end
        start = $urandom_range(0, 5);
        k = 0;
        for (int b = 3; b >= 0; b--) begin
            if (set[b]) begin
                keycode[(start + k) % 6] = code_of(b);
                k++;
            end
        end
        if (k > 0 && k < 6 && $urandom_range(0, 2) == 0) keycode[(start + k) % 6] = keycode[start];
    endtask

    task automatic do_frame(input logic [3:0] set, input logic [3:0] blk, input bit rst_mid);
        @(posedge Clk);
        #1;
        vs = 1'b0;
        scramble();
        if (rst_mid) begin
            Reset = 1'b1;
            model_reset();
            @(negedge Clk);
            check_eq("rst_dir", 32'(dir), 32'h0);
            check_eq("rst_mv", 32'(move_valid), 32'h0);
            check_eq("rst_held", 32'(key_held), 32'h0);
            check_eq("rst_tick", 32'(frame_tick), 32'h0);
            repeat (3) @(posedge Clk);
            #1;
            Reset = 1'b0;
        end
        @(posedge Clk);
        #1;
        load_keys(set);
        blocked = blk;
        @(posedge Clk);
        #1;
        vs = 1'b1;
        model_tick(set, blk);
        @(posedge Clk);
        @(negedge Clk);
        check_eq("tick", 32'(frame_tick), 32'h1);
        check_eq("dir", 32'(dir), 32'(m_dir));
        check_eq("move_valid", 32'(move_valid), 32'(m_mv));
        check_eq("key_held", 32'(key_held), 32'(m_held));
        seen_dir = dir;
        seen_mv  = move_valid;
        @(posedge Clk);
        #1;
        scramble();
        blocked = 4'($urandom);
        @(negedge Clk);
        check_eq("tick_pulse", 32'(frame_tick), 32'h0);
        check_eq("mv_pulse", 32'(move_valid), 32'h0);
        check_eq("dir_hold", 32'(dir), 32'(m_dir));
        check_eq("held_hold", 32'(key_held), 32'(m_held));
    endtask

    initial begin
        logic [3:0] cur;
        int         r;
        for (int i = 0; i < 6; i++) keycode[i] = 8'h00;
        model_reset();
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check_eq("reset_dir", 32'(dir), 32'h0);
        check_eq("reset_mv", 32'(move_valid), 32'h0);
        check_eq("reset_held", 32'(key_held), 32'h0);
        check_eq("reset_tick", 32'(frame_tick), 32'h0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        // Idle keyboard
        for (int f = 0; f < 3; f++) do_frame(4'b0000, 4'b0000, 1'b0);

        // Held D: single step, then repeats only in the repeat build
        for (int f = 1; f <= 22; f++) begin
            do_frame(4'b0001, 4'b0000, 1'b0);
            check_eq("hold_d_mv", 32'(seen_mv),
                     32'((f == 1) || (AutoRep && (f == 13 || f == 17 || f == 21))));
        end
        do_frame(4'b0000, 4'b0000, 1'b0);

        // W held, A joins at frame 5, A released at frame 8
        for (int f = 1; f <= 8; f++) begin
            do_frame((f >= 5 && f <= 7) ? 4'b1010 : 4'b1000, 4'b0000, 1'b0);
            if (f == 5) begin
                check_eq("join_a_dir", 32'(seen_dir), 32'h2);
                check_eq("join_a_mv", 32'(seen_mv), 32'h1);
            end
            if (f == 8) begin
                check_eq("drop_a_dir", 32'(seen_dir), 32'h8);
                check_eq("drop_a_mv", 32'(seen_mv), 32'h1);
            end
        end
        do_frame(4'b0000, 4'b0000, 1'b0);

        // W and D new in the same frame
        do_frame(4'b1001, 4'b0000, 1'b0);
        check_eq("w_d_dir", 32'(seen_dir), 32'h8);
        do_frame(4'b0000, 4'b0000, 1'b0);

        // D against a wall for 12 frames, wall cleared on frame 13
        for (int f = 1; f <= 13; f++) begin
            do_frame(4'b0001, (f <= 12) ? 4'b0001 : 4'b0000, 1'b0);
            check_eq("blk_dir", 32'(seen_dir), 32'h1);
            check_eq("blk_mv", 32'(seen_mv), 32'((f == 13) && AutoRep));
        end
        do_frame(4'b0000, 4'b0000, 1'b0);

        // S held across a mid-frame reset
        for (int f = 1; f <= 4; f++) do_frame(4'b0100, 4'b0000, f == 4);
        check_eq("post_rst_dir", 32'(seen_dir), 32'h4);
        check_eq("post_rst_mv", 32'(seen_mv), 32'h1);

        // Random key evolution with occasional walls and resets
        cur = 4'b0000;
        for (int f = 0; f < 300; f++) begin
            r = $urandom_range(0, 31);
            if (r == 0) cur = 4'b0000;
            else if (r < 4) cur = cur ^ 4'(1 << $urandom_range(0, 3));
            do_frame(cur, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
                     $urandom_range(0, 59) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
